// File: rtl/join_none_pkg.sv
// Shared constants for the join_none launcher: default task delays, widths
// and the bit index assigned to each task in the begin/done/busy vectors.
package join_none_pkg;

  localparam int DEF_DLY_ONE   = 30;
  localparam int DEF_DLY_TWO   = 40;
  localparam int DEF_DLY_THREE = 50;
  localparam int DEF_CNT_W     = 8;
  localparam int DEF_TIME_W    = 32;

  localparam int NUM_TASKS = 3;
  localparam int IDX_ONE   = 0;
  localparam int IDX_TWO   = 1;
  localparam int IDX_THREE = 2;

endpackage : join_none_pkg

// File: rtl/task_timer.sv
// One task slot: load starts a run of dly_i cycles; done_o pulses and busy_o
// drops together on the final cycle of the run.
module task_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] dly_i,
  output logic             busy_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (load_i) begin
      cnt_d  = dly_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        cnt_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule : task_timer

// File: rtl/join_none_launcher.sv
// Launches ONE, TWO (fire-and-forget) and parent THREE together; parent_done_o
// follows THREE only. Define JOIN_NONE_STAMP_EN to add begin/done timestamps.
module join_none_launcher
  import join_none_pkg::*;
#(
  parameter int DLY_ONE   = DEF_DLY_ONE,
  parameter int DLY_TWO   = DEF_DLY_TWO,
  parameter int DLY_THREE = DEF_DLY_THREE,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int TIME_W    = DEF_TIME_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [NUM_TASKS-1:0] begin_o,
  output logic [NUM_TASKS-1:0] done_o,
  output logic [NUM_TASKS-1:0] busy_o,
  output logic                 parent_done_o,
  output logic [TIME_W-1:0]    time_o
`ifdef JOIN_NONE_STAMP_EN
  ,
  output logic [NUM_TASKS-1:0][TIME_W-1:0] stamp_begin_o,
  output logic [NUM_TASKS-1:0][TIME_W-1:0] stamp_done_o
`endif
);

  // Each delay must lie in 1..2^CNT_W-1 to fit the down-counter.
  localparam logic [NUM_TASKS-1:0][CNT_W-1:0] DLY_VEC =
    {CNT_W'(DLY_THREE), CNT_W'(DLY_TWO), CNT_W'(DLY_ONE)};

  logic [NUM_TASKS-1:0] busy, done;
  logic [NUM_TASKS-1:0] begin_q, begin_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic                 accept;

  // A done pulse marks the cycle the last busy bit fell; starts are held off for it.
  assign accept  = start && (busy == '0) && (done == '0);
  assign begin_d = {NUM_TASKS{accept}};
  assign time_d  = time_q + TIME_W'(1);

  for (genvar i = 0; i < NUM_TASKS; i++) begin : g_timer
    task_timer #(.CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (accept),
      .dly_i  (DLY_VEC[i]),
      .busy_o (busy[i]),
      .done_o (done[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      begin_q <= '0;
      time_q  <= '0;
    end else begin
      begin_q <= begin_d;
      time_q  <= time_d;
    end
  end

`ifdef JOIN_NONE_STAMP_EN
  logic [NUM_TASKS-1:0][TIME_W-1:0] stamp_begin_q, stamp_done_q;

  // Captured the edge after each pulse, so time_q is the pulse cycle's time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_begin_q <= '0;
      stamp_done_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_TASKS; i++) begin
        if (begin_q[i]) stamp_begin_q[i] <= time_q;
        if (done[i])    stamp_done_q[i]  <= time_q;
      end
    end
  end

  assign stamp_begin_o = stamp_begin_q;
  assign stamp_done_o  = stamp_done_q;
`endif

  assign begin_o       = begin_q;
  assign done_o        = done;
  assign busy_o        = busy;
  assign parent_done_o = done[IDX_THREE];
  assign time_o        = time_q;

endmodule : join_none_launcher

// File: tb/tb_join_none_launcher.sv
// Directed bench: a cycle table drives a default and a long-children instance
// together, then hand sequences cover mid-run reset and unit delays.
module tb_join_none_launcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_ab = 1'b0;
  logic start_c  = 1'b0;

  logic [2:0]  begin_a, done_a, busy_a, begin_b, done_b, busy_b, begin_c, done_c, busy_c;
  logic        pd_a, pd_b, pd_c;
  logic [31:0] time_a, time_b, time_c;
`ifdef JOIN_NONE_STAMP_EN
  logic [2:0][31:0] sb_a, sd_a, sb_b, sd_b, sb_c, sd_c;
`endif

  always #5 clk = ~clk;

  join_none_launcher dut_a (
    .clk(clk), .rst(rst), .start(start_ab), .begin_o(begin_a), .done_o(done_a),
    .busy_o(busy_a), .parent_done_o(pd_a), .time_o(time_a)
`ifdef JOIN_NONE_STAMP_EN
    , .stamp_begin_o(sb_a), .stamp_done_o(sd_a)
`endif
  );

  join_none_launcher #(.DLY_ONE(60), .DLY_TWO(70), .DLY_THREE(50)) dut_b (
    .clk(clk), .rst(rst), .start(start_ab), .begin_o(begin_b), .done_o(done_b),
    .busy_o(busy_b), .parent_done_o(pd_b), .time_o(time_b)
`ifdef JOIN_NONE_STAMP_EN
    , .stamp_begin_o(sb_b), .stamp_done_o(sd_b)
`endif
  );

  join_none_launcher #(.DLY_ONE(1), .DLY_TWO(1), .DLY_THREE(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .begin_o(begin_c), .done_o(done_c),
    .busy_o(busy_c), .parent_done_o(pd_c), .time_o(time_c)
`ifdef JOIN_NONE_STAMP_EN
    , .stamp_begin_o(sb_c), .stamp_done_o(sd_c)
`endif
  );

  typedef struct {
    logic [2:0] beg;
    logic [2:0] done;
    logic [2:0] busy;
    logic       pd;
  } out_t;

  typedef struct {
    int   cyc;
    logic start;
    out_t a;
    out_t b;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   quiet_cnt;

  function automatic out_t o(input logic [2:0] beg, input logic [2:0] done,
                             input logic [2:0] busy, input logic pd);
    out_t r;
    r.beg = beg; r.done = done; r.busy = busy; r.pd = pd;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] beg, input logic [2:0] done,
                           input logic [2:0] busy, input logic pd, input out_t e);
    check({tag, " begin_o"}, 64'(beg), 64'(e.beg));
    check({tag, " done_o"},  64'(done), 64'(e.done));
    check({tag, " busy_o"},  64'(busy), 64'(e.busy));
    check({tag, " parent_done_o"}, 64'(pd), 64'(e.pd));
  endtask

  // Outputs are sampled and inputs driven on the falling edge; cycle 0 is the
  // cycle in which reset is released (time_o == 0 there).
  task automatic do_reset();
    rst = 1'b1;
    start_ab = 1'b0;
    start_c  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{0,  1'b1, o(3'd0, 3'd0, 3'd0, 1'b0), o(3'd0, 3'd0, 3'd0, 1'b0)};
    tbl[1]  = '{1,  1'b0, o(3'd7, 3'd0, 3'd7, 1'b0), o(3'd7, 3'd0, 3'd7, 1'b0)};
    tbl[2]  = '{2,  1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[3]  = '{20, 1'b1, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[4]  = '{21, 1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[5]  = '{30, 1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[6]  = '{31, 1'b0, o(3'd0, 3'd1, 3'd6, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[7]  = '{32, 1'b0, o(3'd0, 3'd0, 3'd6, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[8]  = '{41, 1'b0, o(3'd0, 3'd2, 3'd4, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[9]  = '{50, 1'b0, o(3'd0, 3'd0, 3'd4, 1'b0), o(3'd0, 3'd0, 3'd7, 1'b0)};
    tbl[10] = '{51, 1'b0, o(3'd0, 3'd4, 3'd0, 1'b1), o(3'd0, 3'd4, 3'd3, 1'b1)};
    tbl[11] = '{52, 1'b1, o(3'd0, 3'd0, 3'd0, 1'b0), o(3'd0, 3'd0, 3'd3, 1'b0)};
    tbl[12] = '{53, 1'b0, o(3'd7, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd3, 1'b0)};
    tbl[13] = '{61, 1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd1, 3'd2, 1'b0)};
    tbl[14] = '{71, 1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd2, 3'd0, 1'b0)};
    tbl[15] = '{72, 1'b0, o(3'd0, 3'd0, 3'd7, 1'b0), o(3'd0, 3'd0, 3'd0, 1'b0)};

    // Table run: start at 0, ignored start at 20, restart at 52 (A idle, B busy).
    do_reset();
    begin
      int p = 0;
      for (int n = 0; n <= 72; n++) begin
        start_ab = 1'b0;
        if (p < NV && tbl[p].cyc == n) begin
          start_ab = tbl[p].start;
          check_out($sformatf("A cyc%0d", n), begin_a, done_a, busy_a, pd_a, tbl[p].a);
          check_out($sformatf("B cyc%0d", n), begin_b, done_b, busy_b, pd_b, tbl[p].b);
          check($sformatf("A time_o cyc%0d", n), 64'(time_a), 64'(n));
          p++;
        end
        @(negedge clk);
      end
      start_ab = 1'b0;
    end

`ifdef JOIN_NONE_STAMP_EN
    check("A stamp_begin", 64'(sb_a), {16'd0, 16'd0} | 64'({32'd53, 32'd53, 32'd53}));
    check("A stamp_done",  64'(sd_a), 64'({32'd51, 32'd41, 32'd31}));
`endif

    // Mid-run reset at cycle 35: everything clears at once, nothing follows.
    do_reset();
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    repeat (34) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_out("A async reset", begin_a, done_a, busy_a, pd_a, o(3'd0, 3'd0, 3'd0, 1'b0));
    check("A async reset time_o", 64'(time_a), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if ((done_a != 3'd0) || (begin_a != 3'd0) || (busy_a != 3'd0) || pd_a) quiet_cnt++;
    end
    check("A activity after aborted run", 64'(quiet_cnt), 64'd0);
    start_ab = 1'b1;
    @(negedge clk);
    start_ab = 1'b0;
    check_out("A clean restart cyc1", begin_a, done_a, busy_a, pd_a, o(3'd7, 3'd0, 3'd7, 1'b0));
    repeat (30) @(negedge clk);
    check_out("A clean restart cyc31", begin_a, done_a, busy_a, pd_a, o(3'd0, 3'd1, 3'd6, 1'b0));

    // Unit delays: simultaneous completion and back-to-back start rejection.
    do_reset();
    repeat (3) @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    check_out("C T+1", begin_c, done_c, busy_c, pd_c, o(3'd7, 3'd0, 3'd7, 1'b0));
    @(negedge clk);
    check_out("C T+2", begin_c, done_c, busy_c, pd_c, o(3'd0, 3'd7, 3'd0, 1'b1));
    start_c = 1'b1;
    @(negedge clk);
    check_out("C T+3 start ignored", begin_c, done_c, busy_c, pd_c, o(3'd0, 3'd0, 3'd0, 1'b0));
    @(negedge clk);
    start_c = 1'b0;
    check_out("C T+4 start accepted", begin_c, done_c, busy_c, pd_c, o(3'd7, 3'd0, 3'd7, 1'b0));
    @(negedge clk);
    check_out("C T+5", begin_c, done_c, busy_c, pd_c, o(3'd0, 3'd7, 3'd0, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_join_none_launcher
